// File: rtl/hamming_fec_decoder.sv
// Hamming(7,4) receive-side FEC decoder.
// Latches a block of NIB codewords on a four-phase req/ack handshake, corrects
// one codeword per enabled cycle and returns the message plus a count of the
// codewords that needed correction.
// Optional build macro HAMMING_FEC_DECODER_ERR_STATS_EN adds err_total, a
// saturating count of all corrected codewords since reset.
module hamming_fec_decoder #(
    parameter  int DATA_W = 8,
    localparam int NIB    = DATA_W / 4,
    localparam int CW_W   = NIB * 7,
    localparam int CNT_W  = $clog2(NIB + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req,
    input  logic [CW_W-1:0]   data_in,
    output logic              ack,
    output logic [DATA_W-1:0] data_out,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic              busy
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
    ,
    output logic [15:0]       err_total
`endif
);

    localparam int             IDX_W    = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DECODE = 2'd1,
        S_ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CW_W-1:0]     cw_q, cw_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
    logic [15:0]         err_total_q, err_total_d;
`endif

    logic [6:0]          cur_cw;
    logic [4:0]          dec_res;
    logic                cur_err;
    logic [3:0]          cur_nib;

    // Syndrome decode of one codeword. Returns {corrected_flag, d3, d2, d1, d0}.
    // Position p lives at bit p-1; a nonzero syndrome names the flipped position.
    function automatic logic [4:0] hamming_correct(input logic [6:0] cw);
        logic [2:0] syn;
        logic [6:0] fixed;
        syn[0] = cw[0] ^ cw[2] ^ cw[4] ^ cw[6];
        syn[1] = cw[1] ^ cw[2] ^ cw[5] ^ cw[6];
        syn[2] = cw[3] ^ cw[4] ^ cw[5] ^ cw[6];
        fixed  = cw;
        if (syn != 3'd0) begin
            fixed[syn - 3'd1] = ~fixed[syn - 3'd1];
        end
        return {(syn != 3'd0), fixed[6], fixed[5], fixed[4], fixed[2]};
    endfunction

    // State and datapath registers; reset clears everything and drops any
    // transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            cw_q    <= '0;
            idx_q   <= '0;
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
            err_total_q <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            cw_q    <= cw_d;
            idx_q   <= idx_d;
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
            err_total_q <= err_total_d;
`endif
        end
    end

    // Select the codeword at the current index and correct it.
    always_comb begin
        cur_cw = 7'd0;
        for (int k = 0; k < NIB; k++) begin
            if (idx_q == IDX_W'(k)) begin
                cur_cw = cw_q[7*k +: 7];
            end
        end
        dec_res = hamming_correct(cur_cw);
        cur_err = dec_res[4];
        cur_nib = dec_res[3:0];
    end

    // Next-state logic. en gates IDLE and DECODE only; the ACK release is
    // never blocked so the four-phase handshake always completes.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (en && req && !ack_q) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (en && (idx_q == IDX_LAST)) begin
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (ack_q && !req) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and registered-output next values for each state.
    always_comb begin
        ack_d  = ack_q;
        busy_d = busy_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        cw_d   = cw_q;
        idx_d  = idx_q;
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
        err_total_d = err_total_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (en && req && !ack_q) begin
                    cw_d   = data_in;
                    cnt_d  = '0;
                    busy_d = 1'b1;
                    idx_d  = '0;
                end
            end
            S_DECODE: begin
                if (en) begin
                    // Overwrite only the nibble being decoded; the rest of the
                    // previous message stays visible until replaced.
                    for (int k = 0; k < NIB; k++) begin
                        if (idx_q == IDX_W'(k)) begin
                            data_d[4*k +: 4] = cur_nib;
                        end
                    end
                    cnt_d = cnt_q + CNT_W'(cur_err);
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
                    if (cur_err && (err_total_q != 16'hFFFF)) begin
                        err_total_d = err_total_q + 16'd1;
                    end
`endif
                    if (idx_q == IDX_LAST) begin
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_ACK: begin
                // First cycle in ACK raises ack; afterwards wait for req to drop.
                if (!ack_q) begin
                    ack_d = 1'b1;
                end else if (!req) begin
                    ack_d  = 1'b0;
                    busy_d = 1'b0;
                end
            end
            default: begin
                ack_d  = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

    assign ack      = ack_q;
    assign busy     = busy_q;
    assign data_out = data_q;
    assign corr_cnt = cnt_q;
`ifdef HAMMING_FEC_DECODER_ERR_STATS_EN
    assign err_total = err_total_q;
`endif

endmodule
